// File: rtl/div_sequencer_if.sv
// Issue/result handshake bundle between the execute stage and div_sequencer.
interface div_sequencer_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       instruction;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, instruction, rs1, rs2, in_tag, flush, out_ready,
        input  in_ready, out_valid, result, out_tag
    );

    modport slave (
        input  in_valid, instruction, rs1, rs2, in_tag, flush, out_ready,
        output in_ready, out_valid, result, out_tag
    );
endinterface

// File: rtl/div_sequencer.sv
// RV64M divide/remainder sequencer: 1-bit-per-cycle restoring division with RISC-V special cases.
// Optional macro EARLY_OUT_EN skips iteration when |divisor| > |dividend|.
module div_sequencer #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5
) (
    input logic            clk,
    input logic            reset,
    div_sequencer_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN + 1);

    localparam logic [7:0] OpDiv   = 8'd14;
    localparam logic [7:0] OpDivu  = 8'd15;
    localparam logic [7:0] OpRem   = 8'd16;
    localparam logic [7:0] OpRemu  = 8'd17;
    localparam logic [7:0] OpDivw  = 8'd39;
    localparam logic [7:0] OpDivuw = 8'd40;
    localparam logic [7:0] OpRemw  = 8'd41;
    localparam logic [7:0] OpRemuw = 8'd42;

    typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

    state_e           r_state, w_state_nxt;
    logic [7:0]       r_op;
    logic [XLEN-1:0]  r_a, r_b, r_rem, r_quo, r_div, r_result;
    logic [TAG_W-1:0] r_tag;
    logic [CntW-1:0]  r_cnt;
    logic             r_neg_q, r_neg_r;

    logic             w_signed, w_word, w_sel_rem, w_legal;
    logic [XLEN-1:0]  w_a_ext, w_b_ext, w_abs_a, w_abs_b, w_min_neg, w_special_res;
    logic             w_sign_a, w_sign_b, w_zero, w_ovf, w_special;
    logic [XLEN:0]    w_part, w_trial;
    logic [XLEN-1:0]  w_q_fix, w_r_fix, w_fixed;
`ifdef EARLY_OUT_EN
    logic             w_early;
`endif

    function automatic logic [XLEN-1:0] word_fmt(input logic word, input logic [XLEN-1:0] v);
        return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    always_comb begin
        w_signed  = 1'b0;
        w_word    = 1'b0;
        w_sel_rem = 1'b0;
        w_legal   = 1'b1;
        case (r_op)
            OpDiv:   w_signed = 1'b1;
            OpDivu:  w_legal = 1'b1;
            OpRem:   begin w_signed = 1'b1; w_sel_rem = 1'b1; end
            OpRemu:  w_sel_rem = 1'b1;
            OpDivw:  begin w_signed = 1'b1; w_word = 1'b1; end
            OpDivuw: w_word = 1'b1;
            OpRemw:  begin w_signed = 1'b1; w_word = 1'b1; w_sel_rem = 1'b1; end
            OpRemuw: begin w_word = 1'b1; w_sel_rem = 1'b1; end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_a_ext = r_a;
        w_b_ext = r_b;
        if (w_word) begin
            w_a_ext = {{(XLEN-32){w_signed & r_a[31]}}, r_a[31:0]};
            w_b_ext = {{(XLEN-32){w_signed & r_b[31]}}, r_b[31:0]};
        end
        w_sign_a  = w_signed & w_a_ext[XLEN-1];
        w_sign_b  = w_signed & w_b_ext[XLEN-1];
        w_abs_a   = w_sign_a ? -w_a_ext : w_a_ext;
        w_abs_b   = w_sign_b ? -w_b_ext : w_b_ext;
        w_min_neg = w_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        w_zero    = (w_b_ext == {XLEN{1'b0}});
        w_ovf     = w_signed & (w_a_ext == w_min_neg) & (&w_b_ext);
        w_special = !w_legal || w_zero || w_ovf;
        if (!w_legal) begin
            w_special_res = {XLEN{1'b0}};
        end else if (w_zero) begin
            w_special_res = word_fmt(w_word, w_sel_rem ? w_a_ext : {XLEN{1'b1}});
        end else begin
            w_special_res = word_fmt(w_word, w_sel_rem ? {XLEN{1'b0}} : w_a_ext);
        end
`ifdef EARLY_OUT_EN
        w_early = (w_abs_b > w_abs_a);
`endif
    end

    // Restoring step: shift the next dividend bit into the partial remainder, trial-subtract.
    always_comb begin
        w_part  = {r_rem, r_quo[XLEN-1]};
        w_trial = w_part - {1'b0, r_div};
        w_q_fix = r_neg_q ? -r_quo : r_quo;
        w_r_fix = r_neg_r ? -r_rem : r_rem;
        w_fixed = word_fmt(w_word, w_sel_rem ? w_r_fix : w_q_fix);
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (bus.in_valid) w_state_nxt = StPrep;
            StPrep: begin
                if (w_special) w_state_nxt = StDone;
`ifdef EARLY_OUT_EN
                else if (w_early) w_state_nxt = StFix;
`endif
                else w_state_nxt = StIter;
            end
            StIter: if (r_cnt == CntW'(1)) w_state_nxt = StFix;
            StFix:  w_state_nxt = StDone;
            StDone: if (bus.out_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        if (bus.flush) w_state_nxt = StIdle;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_tag    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (!bus.flush) begin
            unique case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_op  <= bus.instruction;
                        r_a   <= bus.rs1;
                        r_b   <= bus.rs2;
                        r_tag <= bus.in_tag;
                    end
                end
                StPrep: begin
                    r_neg_q <= w_sign_a ^ w_sign_b;
                    r_neg_r <= w_sign_a;
                    r_div   <= w_abs_b;
                    r_rem   <= '0;
                    // Word ops start with the 32-bit dividend left-aligned so 32 steps suffice.
                    r_quo   <= w_word ? {w_abs_a[31:0], {(XLEN-32){1'b0}}} : w_abs_a;
                    r_cnt   <= w_word ? CntW'(32) : CntW'(XLEN);
                    if (w_special) r_result <= w_special_res;
`ifdef EARLY_OUT_EN
                    if (w_early) begin
                        r_quo <= '0;
                        r_rem <= w_abs_a;
                    end
`endif
                end
                StIter: begin
                    if (w_trial[XLEN]) begin
                        r_rem <= w_part[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b0};
                    end else begin
                        r_rem <= w_trial[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b1};
                    end
                    r_cnt <= r_cnt - CntW'(1);
                end
                StFix:   r_result <= w_fixed;
                default: begin end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.result    = r_result;
    assign bus.out_tag   = r_tag;
endmodule
